registro_id_ex: RTL and testbench
=================================

# registro_id_ex

Decode-to-execute pipeline register feeding the ALU stage. Accepts one decoded ALU operation per cycle (two 32-bit operands, 3-bit SEL, register indices) over a valid/ready handshake. Presents it to the ALU inputs one cycle later. A two-entry skid buffer keeps full throughput under downstream stalls with no combinational ready path. Supports synchronous flush and optional operand forwarding from the writeback result.

## Interface
- ANCHO, 32, operand/result width
- ANCHO_REG, 5, register-index width
- ANCHO_SEL, 3, ALU operation select width
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- ENT_VALIDO  in  1  upstream entry valid
- ENT_LISTO  out  1  block can accept; registered
- ENT_OPERADOR1, ENT_OPERADOR2  in  ANCHO  decoded operands
- ENT_SEL  in  ANCHO_SEL  ALU operation
- ENT_RS, ENT_RT, ENT_RD  in  ANCHO_REG  source/destination indices
- ENT_USA_IMM  in  1  OPERADOR2 is an immediate, never forwarded
- VACIAR  in  1  synchronous flush
- SAL_VALIDO  out  1  ALU inputs valid
- SAL_LISTO  in  1  downstream accepts
- OPERADOR1, OPERADOR2  out  ANCHO  to ALU
- SEL  out  ANCHO_SEL  to ALU
- SAL_RD  out  ANCHO_REG  destination carried forward
- FWD_VALIDO  in  1  writeback valid (REGISTRO_ID_EX_FWD_EN only)
- FWD_RD  in  ANCHO_REG  writeback destination (REGISTRO_ID_EX_FWD_EN only)
- FWD_DATO  in  ANCHO  writeback value (REGISTRO_ID_EX_FWD_EN only)

## Operation
- Transfers: accept = ENT_VALIDO & ENT_LISTO; emit = SAL_VALIDO & SAL_LISTO.
- Storage: main slot drives outputs; skid slot holds overflow.
- States: VACIO, UNO, LLENO.
- VACIO: accept -> UNO.
- UNO, accept & !emit -> LLENO; entry goes to skid.
- UNO, accept & emit -> UNO; main reloads.
- UNO, !accept & emit -> VACIO.
- LLENO: emit -> UNO; skid moves to main. ENT_VALIDO is ignored.
- ENT_LISTO = (state != LLENO). SAL_VALIDO = (state != VACIO).
- Order is strictly FIFO. No entry is duplicated or dropped except by flush.
- VACIAR has priority over all transfers. Next state is VACIO. Same-cycle accept is discarded. Data registers hold their values; only validity clears.
- Outputs are registered. No combinational path from any input to any output.
- All fields pass unmodified except as forwarding dictates. No width conversion.

## Timing
- Latency: accepted at edge N -> SAL_VALIDO with data after edge N.
- Throughput: 1 op/cycle while SAL_LISTO=1.
- Reset: state VACIO; ENT_LISTO=1 during reset; SAL_VALIDO=0; OPERADOR1/2=0, SEL=3'b000, SAL_RD=0; skid cleared.
- RST asserted mid-operation discards all entries immediately.
- Stall: while SAL_LISTO=0 and SAL_VALIDO=1, outputs are stable; forwarding updates are the only exception.
- Simultaneous emit from LLENO plus ENT_VALIDO: no accept that cycle; ENT_LISTO rises after the edge.

## Configuration
- REGISTRO_ID_EX_FWD_EN defined:
  - On capture, and every cycle for entries held in main or skid, if FWD_VALIDO & FWD_RD != 0:
    - FWD_RD == RS -> OPERADOR1 := FWD_DATO.
    - FWD_RD == RT & !USA_IMM -> OPERADOR2 := FWD_DATO.
  - Held RS/RT/USA_IMM are stored per slot.
- Undefined:
  - FWD_* ports are absent.
  - Operands are captured verbatim.
  - RS/RT/USA_IMM storage is removed.

## Structure
- Shared package paquete_alu:
  - SEL encodings: AND 000, OR 001, ADD 010, SUB 110, SLT 111, NOR 100.
  - ANCHO/ANCHO_REG/ANCHO_SEL defaults.
  - State enum (VACIO, UNO, LLENO).
- Sub-module ranura_id_ex: one slot with load, hold and forwarding update. It is instantiated twice (main, skid). The parent owns the state machine and muxing.

## Test plan
- Reset then ENT_VALIDO=1, OPERADOR1=7, OPERADOR2=5, SEL=010, SAL_LISTO=1 -> next cycle SAL_VALIDO=1, OPERADOR1=7, OPERADOR2=5, SEL=010; streaming 8 ops emits 8 in order, one per cycle.
- SAL_LISTO=0 with 3 back-to-back inputs A,B,C:
  - A in main, B in skid.
  - ENT_LISTO=0 after the second accept; C is held upstream.
  - Releasing SAL_LISTO emits A,B,C in order with no gaps.
- LLENO, then VACIAR=1 with ENT_VALIDO=1 -> next cycle SAL_VALIDO=0, ENT_LISTO=1; the input is not emitted.
- RST pulsed while LLENO -> outputs immediately zero/invalid, ENT_LISTO=1.
- FWD_EN, RS=3, RT=3:
  - FWD_RD=3, FWD_DATO=0xDEADBEEF at capture -> both operands 0xDEADBEEF.
  - With USA_IMM=1 -> only OPERADOR1 changes.
  - FWD_RD=0 -> no change.
- FWD_EN, entry stalled in skid with RS=4; FWD_RD=4, FWD_DATO=9 arrives -> emitted OPERADOR1=9.

Source files
------------

// File: rtl/registro_id_ex_pkg.sv
// paquete_alu: ALU select encodings, default widths and the ID/EX
// occupancy state type shared by the decode-to-execute register.
package paquete_alu;

    localparam int ANCHO_DEF     = 32;
    localparam int ANCHO_REG_DEF = 5;
    localparam int ANCHO_SEL_DEF = 3;

    localparam logic [2:0] SEL_AND = 3'b000;
    localparam logic [2:0] SEL_OR  = 3'b001;
    localparam logic [2:0] SEL_ADD = 3'b010;
    localparam logic [2:0] SEL_SUB = 3'b110;
    localparam logic [2:0] SEL_SLT = 3'b111;
    localparam logic [2:0] SEL_NOR = 3'b100;

    typedef enum logic [1:0] {
        VACIO,
        UNO,
        LLENO
    } estado_t;

endpackage

// File: rtl/registro_id_ex_if.sv
// registro_id_ex_if: upstream/downstream handshake bundle of the ID/EX
// register; FWD_* members exist only with REGISTRO_ID_EX_FWD_EN.
interface registro_id_ex_if #(
    parameter int ANCHO     = paquete_alu::ANCHO_DEF,
    parameter int ANCHO_REG = paquete_alu::ANCHO_REG_DEF,
    parameter int ANCHO_SEL = paquete_alu::ANCHO_SEL_DEF
) ();

    logic                 ENT_VALIDO;
    logic                 ENT_LISTO;
    logic [ANCHO-1:0]     ENT_OPERADOR1;
    logic [ANCHO-1:0]     ENT_OPERADOR2;
    logic [ANCHO_SEL-1:0] ENT_SEL;
    logic [ANCHO_REG-1:0] ENT_RS;
    logic [ANCHO_REG-1:0] ENT_RT;
    logic [ANCHO_REG-1:0] ENT_RD;
    logic                 ENT_USA_IMM;
    logic                 VACIAR;
    logic                 SAL_VALIDO;
    logic                 SAL_LISTO;
    logic [ANCHO-1:0]     OPERADOR1;
    logic [ANCHO-1:0]     OPERADOR2;
    logic [ANCHO_SEL-1:0] SEL;
    logic [ANCHO_REG-1:0] SAL_RD;
`ifdef REGISTRO_ID_EX_FWD_EN
    logic                 FWD_VALIDO;
    logic [ANCHO_REG-1:0] FWD_RD;
    logic [ANCHO-1:0]     FWD_DATO;
`endif

    modport slave (
        input  ENT_VALIDO, ENT_OPERADOR1, ENT_OPERADOR2, ENT_SEL,
        input  ENT_RS, ENT_RT, ENT_RD, ENT_USA_IMM, VACIAR, SAL_LISTO,
`ifdef REGISTRO_ID_EX_FWD_EN
        input  FWD_VALIDO, FWD_RD, FWD_DATO,
`endif
        output ENT_LISTO, SAL_VALIDO, OPERADOR1, OPERADOR2, SEL, SAL_RD
    );

    modport master (
        output ENT_VALIDO, ENT_OPERADOR1, ENT_OPERADOR2, ENT_SEL,
        output ENT_RS, ENT_RT, ENT_RD, ENT_USA_IMM, VACIAR, SAL_LISTO,
`ifdef REGISTRO_ID_EX_FWD_EN
        output FWD_VALIDO, FWD_RD, FWD_DATO,
`endif
        input  ENT_LISTO, SAL_VALIDO, OPERADOR1, OPERADOR2, SEL, SAL_RD
    );

endinterface

// File: rtl/registro_id_ex_ranura.sv
// ranura_id_ex: one ID/EX holding slot with load, hold and, when
// REGISTRO_ID_EX_FWD_EN is defined, writeback forwarding into its operands.
module ranura_id_ex
    import paquete_alu::*;
#(
    parameter int ANCHO     = ANCHO_DEF,
    parameter int ANCHO_REG = ANCHO_REG_DEF,
    parameter int ANCHO_SEL = ANCHO_SEL_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 carga,
    input  logic [ANCHO-1:0]     d_op1,
    input  logic [ANCHO-1:0]     d_op2,
    input  logic [ANCHO_SEL-1:0] d_sel,
    input  logic [ANCHO_REG-1:0] d_rd,
`ifdef REGISTRO_ID_EX_FWD_EN
    input  logic [ANCHO_REG-1:0] d_rs,
    input  logic [ANCHO_REG-1:0] d_rt,
    input  logic                 d_imm,
    input  logic                 fwd_valido,
    input  logic [ANCHO_REG-1:0] fwd_rd,
    input  logic [ANCHO-1:0]     fwd_dato,
    output logic [ANCHO_REG-1:0] q_rs,
    output logic [ANCHO_REG-1:0] q_rt,
    output logic                 q_imm,
`endif
    output logic [ANCHO-1:0]     q_op1,
    output logic [ANCHO-1:0]     q_op2,
    output logic [ANCHO_SEL-1:0] q_sel,
    output logic [ANCHO_REG-1:0] q_rd
);

    logic [ANCHO-1:0]     op1_q, op1_d;
    logic [ANCHO-1:0]     op2_q, op2_d;
    logic [ANCHO_SEL-1:0] sel_q, sel_d;
    logic [ANCHO_REG-1:0] rd_q, rd_d;
`ifdef REGISTRO_ID_EX_FWD_EN
    logic [ANCHO_REG-1:0] rs_q, rs_d;
    logic [ANCHO_REG-1:0] rt_q, rt_d;
    logic                 imm_q, imm_d;
`endif

    always_comb begin
        op1_d = carga ? d_op1 : op1_q;
        op2_d = carga ? d_op2 : op2_q;
        sel_d = carga ? d_sel : sel_q;
        rd_d  = carga ? d_rd  : rd_q;
`ifdef REGISTRO_ID_EX_FWD_EN
        rs_d  = carga ? d_rs  : rs_q;
        rt_d  = carga ? d_rt  : rt_q;
        imm_d = carga ? d_imm : imm_q;
        // Same rule on capture and while held; r0 is never forwarded.
        if (fwd_valido && fwd_rd != '0) begin
            if (fwd_rd == rs_d) op1_d = fwd_dato;
            if (fwd_rd == rt_d && !imm_d) op2_d = fwd_dato;
        end
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op1_q <= '0;
            op2_q <= '0;
            sel_q <= '0;
            rd_q  <= '0;
`ifdef REGISTRO_ID_EX_FWD_EN
            rs_q  <= '0;
            rt_q  <= '0;
            imm_q <= 1'b0;
`endif
        end else begin
            op1_q <= op1_d;
            op2_q <= op2_d;
            sel_q <= sel_d;
            rd_q  <= rd_d;
`ifdef REGISTRO_ID_EX_FWD_EN
            rs_q  <= rs_d;
            rt_q  <= rt_d;
            imm_q <= imm_d;
`endif
        end
    end

    assign q_op1 = op1_q;
    assign q_op2 = op2_q;
    assign q_sel = sel_q;
    assign q_rd  = rd_q;
`ifdef REGISTRO_ID_EX_FWD_EN
    assign q_rs  = rs_q;
    assign q_rt  = rt_q;
    assign q_imm = imm_q;
`endif

endmodule

// File: rtl/registro_id_ex.sv
// registro_id_ex: ID/EX register with two-entry skid buffer and flush.
// Define REGISTRO_ID_EX_FWD_EN to forward the writeback result into held ops.
module registro_id_ex
    import paquete_alu::*;
#(
    parameter int ANCHO     = ANCHO_DEF,
    parameter int ANCHO_REG = ANCHO_REG_DEF,
    parameter int ANCHO_SEL = ANCHO_SEL_DEF
) (
    input logic             CLK,
    input logic             RST,
    registro_id_ex_if.slave bus
);

    estado_t estado_q, estado_d;
    logic    acepta, emite;
    logic    carga_pri, carga_sec, desde_sec;

    logic [ANCHO-1:0]     pri_op1, pri_op2, sec_op1, sec_op2;
    logic [ANCHO-1:0]     pri_op1_d, pri_op2_d;
    logic [ANCHO_SEL-1:0] pri_sel, sec_sel, pri_sel_d;
    logic [ANCHO_REG-1:0] pri_rd, sec_rd, pri_rd_d;

    assign acepta    = bus.ENT_VALIDO && bus.ENT_LISTO;
    assign emite     = bus.SAL_VALIDO && bus.SAL_LISTO;
    assign desde_sec = (estado_q == LLENO);

    always_comb begin
        estado_d  = estado_q;
        carga_pri = 1'b0;
        carga_sec = 1'b0;
        // Flush wins; slot contents are kept, only occupancy is dropped.
        if (bus.VACIAR) begin
            estado_d = VACIO;
        end else begin
            unique case (estado_q)
                VACIO: begin
                    if (acepta) begin
                        estado_d  = UNO;
                        carga_pri = 1'b1;
                    end
                end
                UNO: begin
                    if (acepta && emite) begin
                        carga_pri = 1'b1;
                    end else if (acepta) begin
                        estado_d  = LLENO;
                        carga_sec = 1'b1;
                    end else if (emite) begin
                        estado_d = VACIO;
                    end
                end
                LLENO: begin
                    if (emite) begin
                        estado_d  = UNO;
                        carga_pri = 1'b1;
                    end
                end
                default: estado_d = VACIO;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) estado_q <= VACIO;
        else     estado_q <= estado_d;
    end

    assign pri_op1_d = desde_sec ? sec_op1 : bus.ENT_OPERADOR1;
    assign pri_op2_d = desde_sec ? sec_op2 : bus.ENT_OPERADOR2;
    assign pri_sel_d = desde_sec ? sec_sel : bus.ENT_SEL;
    assign pri_rd_d  = desde_sec ? sec_rd  : bus.ENT_RD;

`ifdef REGISTRO_ID_EX_FWD_EN
    logic [ANCHO_REG-1:0] sec_rs, sec_rt, pri_rs_d, pri_rt_d;
    logic                 sec_imm, pri_imm_d;
    logic [ANCHO_REG-1:0] pri_rs_unused, pri_rt_unused;
    logic                 pri_imm_unused;

    assign pri_rs_d  = desde_sec ? sec_rs  : bus.ENT_RS;
    assign pri_rt_d  = desde_sec ? sec_rt  : bus.ENT_RT;
    assign pri_imm_d = desde_sec ? sec_imm : bus.ENT_USA_IMM;
`else
    logic unused_campos;
    assign unused_campos = ^{bus.ENT_RS, bus.ENT_RT, bus.ENT_USA_IMM};
`endif

    ranura_id_ex #(
        .ANCHO     (ANCHO),
        .ANCHO_REG (ANCHO_REG),
        .ANCHO_SEL (ANCHO_SEL)
    ) u_principal (
        .CLK        (CLK),
        .RST        (RST),
        .carga      (carga_pri),
        .d_op1      (pri_op1_d),
        .d_op2      (pri_op2_d),
        .d_sel      (pri_sel_d),
        .d_rd       (pri_rd_d),
`ifdef REGISTRO_ID_EX_FWD_EN
        .d_rs       (pri_rs_d),
        .d_rt       (pri_rt_d),
        .d_imm      (pri_imm_d),
        .fwd_valido (bus.FWD_VALIDO),
        .fwd_rd     (bus.FWD_RD),
        .fwd_dato   (bus.FWD_DATO),
        .q_rs       (pri_rs_unused),
        .q_rt       (pri_rt_unused),
        .q_imm      (pri_imm_unused),
`endif
        .q_op1      (pri_op1),
        .q_op2      (pri_op2),
        .q_sel      (pri_sel),
        .q_rd       (pri_rd)
    );

    ranura_id_ex #(
        .ANCHO     (ANCHO),
        .ANCHO_REG (ANCHO_REG),
        .ANCHO_SEL (ANCHO_SEL)
    ) u_secundaria (
        .CLK        (CLK),
        .RST        (RST),
        .carga      (carga_sec),
        .d_op1      (bus.ENT_OPERADOR1),
        .d_op2      (bus.ENT_OPERADOR2),
        .d_sel      (bus.ENT_SEL),
        .d_rd       (bus.ENT_RD),
`ifdef REGISTRO_ID_EX_FWD_EN
        .d_rs       (bus.ENT_RS),
        .d_rt       (bus.ENT_RT),
        .d_imm      (bus.ENT_USA_IMM),
        .fwd_valido (bus.FWD_VALIDO),
        .fwd_rd     (bus.FWD_RD),
        .fwd_dato   (bus.FWD_DATO),
        .q_rs       (sec_rs),
        .q_rt       (sec_rt),
        .q_imm      (sec_imm),
`endif
        .q_op1      (sec_op1),
        .q_op2      (sec_op2),
        .q_sel      (sec_sel),
        .q_rd       (sec_rd)
    );

    assign bus.ENT_LISTO  = (estado_q != LLENO);
    assign bus.SAL_VALIDO = (estado_q != VACIO);
    assign bus.OPERADOR1  = pri_op1;
    assign bus.OPERADOR2  = pri_op2;
    assign bus.SEL        = pri_sel;
    assign bus.SAL_RD     = pri_rd;

endmodule

// File: tb/tb_registro_id_ex.sv
// tb_registro_id_ex: scoreboard bench for registro_id_ex; forwarding
// vectors run when REGISTRO_ID_EX_FWD_EN is defined.
module tb_registro_id_ex;
    import paquete_alu::*;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  sel;
        logic [4:0]  rd;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   ciclo = 0;
    int   compared = 0;
    int   mismatched = 0;
    item_t esperado[$];
    int    t_emit[$];
    logic [2:0] sels [6] = '{SEL_AND, SEL_OR, SEL_ADD,
                             SEL_SUB, SEL_SLT, SEL_NOR};

    registro_id_ex_if bus ();

    registro_id_ex dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ciclo <= ciclo + 1;

    function automatic item_t mk(input logic [31:0] a, b,
                                 input logic [2:0] s,
                                 input logic [4:0] r);
        item_t t;
        t.op1 = a; t.op2 = b; t.sel = s; t.rd = r;
        return t;
    endfunction

    function automatic item_t salida();
        item_t t;
        t.op1 = bus.OPERADOR1; t.op2 = bus.OPERADOR2;
        t.sel = bus.SEL;       t.rd  = bus.SAL_RD;
        return t;
    endfunction

    task automatic chk(input string nombre,
                       input logic [71:0] act, input logic [71:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nombre, act, exp);
        end
    endtask

    // Monitor: every emitted op is matched against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus.SAL_VALIDO && bus.SAL_LISTO) begin
            t_emit.push_back(ciclo);
            if (esperado.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL emit_extra: got %h expected none", salida());
            end else begin
                chk("emit", salida(), esperado.pop_front());
            end
        end
    end

    task automatic poner(input item_t d, input logic [4:0] rs, rt,
                         input logic imm);
        bus.ENT_OPERADOR1 = d.op1;
        bus.ENT_OPERADOR2 = d.op2;
        bus.ENT_SEL       = d.sel;
        bus.ENT_RD        = d.rd;
        bus.ENT_RS        = rs;
        bus.ENT_RT        = rt;
        bus.ENT_USA_IMM   = imm;
        bus.ENT_VALIDO    = 1'b1;
    endtask

    task automatic enviar(input item_t d, input logic [4:0] rs, rt,
                          input logic imm, input item_t e);
        logic listo;
        bit   ok;
        ok = 1'b0;
        poner(d, rs, rt, imm);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            listo = bus.ENT_LISTO;
            @(posedge clk);
            #1;
            if (listo) ok = 1'b1;
        end
        bus.ENT_VALIDO = 1'b0;
        if (ok) begin
            esperado.push_back(e);
        end else begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: got ENT_LISTO=0 expected 1");
        end
    endtask

    task automatic env(input item_t d);
        enviar(d, 5'd0, 5'd0, 1'b0, d);
    endtask

    task automatic esperar_vacio();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (esperado.size() == 0) return;
        end
        compared++;
        mismatched++;
        $display("FAIL drain_timeout: got %0d pending expected 0",
                 esperado.size());
    endtask

    function automatic int span();
        return (t_emit.size() > 0) ? t_emit[$] - t_emit[0] : -1;
    endfunction

    initial begin
        item_t a, b, c, g;
        bus.ENT_VALIDO = 1'b0;
        bus.VACIAR     = 1'b0;
        bus.SAL_LISTO  = 1'b0;
        poner(mk(0, 0, 0, 0), 5'd0, 5'd0, 1'b0);
        bus.ENT_VALIDO = 1'b0;
`ifdef REGISTRO_ID_EX_FWD_EN
        bus.FWD_VALIDO = 1'b0;
        bus.FWD_RD     = '0;
        bus.FWD_DATO   = '0;
`endif
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ent_listo", 72'(bus.ENT_LISTO), 72'(1));
        chk("rst_sal_valido", 72'(bus.SAL_VALIDO), 72'(0));
        chk("rst_datos", salida(), mk(0, 0, 0, 0));
        rst = 1'b0;

        // Single op latency, then an 8-op stream with no stalls
        bus.SAL_LISTO = 1'b1;
        t_emit.delete();
        env(mk(7, 5, SEL_ADD, 5'd1));
        chk("lat_valido", 72'(bus.SAL_VALIDO), 72'(1));
        chk("lat_datos", salida(), mk(7, 5, SEL_ADD, 5'd1));
        for (int k = 0; k < 8; k++)
            env(mk(k + 1, 100 + k, sels[k % 6], 5'(k + 2)));
        esperar_vacio();
        chk("stream_n", 72'(t_emit.size()), 72'(9));
        chk("stream_span", 72'(span()), 72'(8));

        // Stall: A in main, B in skid, C held upstream
        a = mk(32'hA, 32'h1A, SEL_SUB, 5'd10);
        b = mk(32'hB, 32'h1B, SEL_OR, 5'd11);
        c = mk(32'hC, 32'h1C, SEL_SLT, 5'd12);
        bus.SAL_LISTO = 1'b0;
        t_emit.delete();
        env(a);
        env(b);
        chk("stall_ent_listo", 72'(bus.ENT_LISTO), 72'(0));
        chk("stall_main", salida(), a);
        poner(c, 5'd0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("stall_stable", salida(), a);
        chk("stall_hold_c", 72'(bus.ENT_LISTO), 72'(0));
        bus.SAL_LISTO = 1'b1;
        env(c);
        esperar_vacio();
        chk("stall_n", 72'(t_emit.size()), 72'(3));
        chk("stall_span", 72'(span()), 72'(2));

        // Flush from LLENO with a competing input
        bus.SAL_LISTO = 1'b0;
        env(mk(32'hD, 1, SEL_AND, 5'd13));
        env(mk(32'hE, 2, SEL_AND, 5'd14));
        poner(mk(32'hF, 3, SEL_NOR, 5'd15), 5'd0, 5'd0, 1'b0);
        bus.VACIAR = 1'b1;
        @(posedge clk);
        #1;
        bus.VACIAR = 1'b0;
        bus.ENT_VALIDO = 1'b0;
        esperado.delete();
        chk("flush_valido", 72'(bus.SAL_VALIDO), 72'(0));
        chk("flush_listo", 72'(bus.ENT_LISTO), 72'(1));

        // Flush from UNO discards a same-cycle accept
        g = mk(32'h60, 32'h61, SEL_OR, 5'd16);
        env(g);
        poner(mk(32'h70, 32'h71, SEL_SUB, 5'd17), 5'd0, 5'd0, 1'b0);
        bus.VACIAR = 1'b1;
        @(posedge clk);
        #1;
        bus.VACIAR = 1'b0;
        bus.ENT_VALIDO = 1'b0;
        esperado.delete();
        chk("flush1_valido", 72'(bus.SAL_VALIDO), 72'(0));
        chk("flush1_hold", 72'(bus.OPERADOR1), 72'(32'h60));
        t_emit.delete();
        bus.SAL_LISTO = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("flush_no_emit", 72'(t_emit.size()), 72'(0));

        // Asynchronous reset while LLENO
        bus.SAL_LISTO = 1'b0;
        env(mk(32'h80, 32'h81, SEL_ADD, 5'd18));
        env(mk(32'h90, 32'h91, SEL_ADD, 5'd19));
        #2 rst = 1'b1;
        #1;
        chk("arst_listo", 72'(bus.ENT_LISTO), 72'(1));
        chk("arst_valido", 72'(bus.SAL_VALIDO), 72'(0));
        chk("arst_datos", salida(), mk(0, 0, 0, 0));
        esperado.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        bus.SAL_LISTO = 1'b1;
        env(mk(32'h1234, 32'h5678, SEL_SLT, 5'd20));
        esperar_vacio();

`ifdef REGISTRO_ID_EX_FWD_EN
        // Forwarding on capture
        bus.FWD_VALIDO = 1'b1;
        bus.FWD_RD     = 5'd3;
        bus.FWD_DATO   = 32'hDEADBEEF;
        enviar(mk(1, 2, SEL_ADD, 5'd7), 5'd3, 5'd3, 1'b0,
               mk(32'hDEADBEEF, 32'hDEADBEEF, SEL_ADD, 5'd7));
        enviar(mk(1, 2, SEL_ADD, 5'd8), 5'd3, 5'd3, 1'b1,
               mk(32'hDEADBEEF, 2, SEL_ADD, 5'd8));
        bus.FWD_RD = 5'd0;
        enviar(mk(1, 2, SEL_ADD, 5'd9), 5'd0, 5'd0, 1'b0,
               mk(1, 2, SEL_ADD, 5'd9));
        bus.FWD_VALIDO = 1'b0;
        esperar_vacio();

        // Forwarding into an entry waiting in the skid slot
        bus.SAL_LISTO = 1'b0;
        env(mk(11, 12, SEL_OR, 5'd21));
        enviar(mk(100, 200, SEL_SUB, 5'd22), 5'd4, 5'd5, 1'b0,
               mk(9, 200, SEL_SUB, 5'd22));
        bus.FWD_VALIDO = 1'b1;
        bus.FWD_RD     = 5'd4;
        bus.FWD_DATO   = 32'd9;
        @(posedge clk);
        #1;
        bus.FWD_VALIDO = 1'b0;
        bus.SAL_LISTO  = 1'b1;
        esperar_vacio();
`endif

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
